// File: rtl/imem_fetch.sv
// imem_fetch: issues one imem read per PC and buffers in-order responses for decode,
// discarding everything in flight or buffered on a redirect flush.
module imem_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_flush,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
  input  logic                  i_mem_rsp_err,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_fault
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [DATA_WIDTH-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0] fault_q, filled_q;
  logic [PW-1:0] wr, fill, rd, drop_cnt, occupancy, pending;
  logic [PW:0] used;
  logic credit, issue, rsp_drop, rsp_fill, rsp_live, pop;
  assign occupancy = wr - rd;
  assign pending = wr - fill;
  // Dropped responses still occupy memory-side slots, so they consume credit too.
  assign used = {1'b0, occupancy} + {1'b0, drop_cnt};
  assign credit = used < FULL;
  assign o_mem_req_valid = i_valid & credit & ~i_flush;
  assign o_ready = i_mem_req_ready & credit & ~i_flush;
  assign o_mem_req_addr = i_pc;
  assign issue = o_mem_req_valid & i_mem_req_ready;
  assign rsp_drop = i_mem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = i_mem_rsp_valid & (drop_cnt == '0) & (pending != '0);
  assign rsp_live = i_mem_rsp_valid & ((drop_cnt != '0) | (pending != '0));
  assign o_valid = filled_q[rd[IW-1:0]] & (occupancy != '0) & ~i_flush;
  assign pop = o_valid & i_ready;
  assign o_pc = pc_q[rd[IW-1:0]];
  assign o_inst = inst_q[rd[IW-1:0]];
  assign o_fault = fault_q[rd[IW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr <= '0;
      fill <= '0;
      rd <= '0;
      drop_cnt <= '0;
      fault_q <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else if (i_flush) begin
      wr <= '0;
      fill <= '0;
      rd <= '0;
      filled_q <= '0;
      drop_cnt <= drop_cnt + pending - PW'(rsp_live);
    end else begin
      if (issue) begin
        pc_q[wr[IW-1:0]] <= i_pc;
        filled_q[wr[IW-1:0]] <= 1'b0;
        wr <= wr + PW'(1);
      end
      if (rsp_drop) drop_cnt <= drop_cnt - PW'(1);
      if (rsp_fill) begin
        inst_q[fill[IW-1:0]] <= i_mem_rsp_data;
        fault_q[fill[IW-1:0]] <= i_mem_rsp_err;
        filled_q[fill[IW-1:0]] <= 1'b1;
        fill <= fill + PW'(1);
      end
      if (pop) begin
        filled_q[rd[IW-1:0]] <= 1'b0;
        rd <= rd + PW'(1);
      end
    end
  end
  // A response with nothing outstanding is a memory protocol error and is ignored.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_mem_rsp_valid && drop_cnt == '0 && pending == '0));
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: randomized and directed checks of imem_fetch against a queue-based fetch model.
module tb_imem_fetch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  logic i_valid = 1'b0, i_flush = 1'b0, i_mem_req_ready = 1'b0, i_ready = 1'b0;
  logic i_mem_rsp_valid = 1'b0, i_mem_rsp_err = 1'b0;
  logic [AW-1:0] i_pc = '0;
  logic [DW-1:0] i_mem_rsp_data = '0;
  logic o_ready, o_mem_req_valid, o_valid, o_fault;
  logic [AW-1:0] o_mem_req_addr, o_pc;
  logic [DW-1:0] o_inst;

  imem_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
    .i_flush(i_flush), .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_addr(o_mem_req_addr), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data(i_mem_rsp_data), .i_mem_rsp_err(i_mem_rsp_err), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_inst(o_inst), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] inst; logic fault; } ent_t;
  typedef struct { logic [AW-1:0] addr; int due; } req_t;
  logic [AW-1:0] live [$];
  ent_t done_q [$];
  req_t mem_q [$];
  int dead, cyc, lat, last_due, passed, total, pops, first_pop, last_pop;
  logic fired, exp_valid;

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] a);
    return (a ^ 32'h8000_0000) * 32'd3 + 32'h13;
  endfunction

  function automatic logic err_of(input logic [AW-1:0] a);
    return a[31:28] == 4'hF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycle(input logic v, input logic [AW-1:0] pc, input logic mr, input logic rdy, input logic fl);
    logic rsp, req;
    logic [AW-1:0] p;
    int used, due;
    @(negedge i_clk);
    rsp = mem_q.size() > 0 && mem_q[0].due == cyc;
    i_valid = v;
    i_pc = pc;
    i_mem_req_ready = mr;
    i_ready = rdy;
    i_flush = fl;
    i_mem_rsp_valid = rsp;
    i_mem_rsp_data = '0;
    i_mem_rsp_err = 1'b0;
    if (rsp) begin
      i_mem_rsp_data = inst_of(mem_q[0].addr);
      i_mem_rsp_err = err_of(mem_q[0].addr);
    end
    #1;
    used = live.size() + done_q.size() + dead;
    req = v && used < DEPTH && !fl;
    exp_valid = done_q.size() > 0 && !fl;
    check("o_valid", o_valid, exp_valid);
    check("o_mem_req_valid", o_mem_req_valid, req);
    check("o_ready", o_ready, mr && used < DEPTH && !fl);
    if (req) check("o_mem_req_addr", o_mem_req_addr, pc);
    if (done_q.size() > 0) begin
      check("o_pc", o_pc, done_q[0].pc);
      check("o_inst", o_inst, done_q[0].inst);
      check("o_fault", o_fault, done_q[0].fault);
    end
    @(posedge i_clk);
    fired = req && mr;
    if (rsp) void'(mem_q.pop_front());
    if (fired) begin
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      mem_q.push_back('{pc, due});
      last_due = due;
    end
    if (fl) begin
      dead = dead + live.size() - int'(rsp);
      live.delete();
      done_q.delete();
    end else begin
      if (rsp) begin
        if (dead > 0) dead--;
        else begin
          p = live.pop_front();
          done_q.push_back('{p, inst_of(p), err_of(p)});
        end
      end
      if (exp_valid && rdy) begin
        void'(done_q.pop_front());
        pops++;
        if (pops == 1) first_pop = cyc;
        last_pop = cyc;
      end
      if (fired) live.push_back(pc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic expect_head(input string tag, input logic [AW-1:0] pc, input logic [DW-1:0] inst,
                             input logic f, output int k);
    k = 0;
    #1;
    while (!o_valid && k < 20) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      k++;
    end
    check({tag, ".valid"}, o_valid, 1'b1);
    check({tag, ".pc"}, o_pc, pc);
    check({tag, ".inst"}, o_inst, inst);
    check({tag, ".fault"}, o_fault, f);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    i_mem_req_ready = 1'b1;
    #1;
    check("rst.pre_valid", o_valid, done_q.size() > 0);
    i_rst_n = 1'b0;
    #1;
    check("rst.o_valid", o_valid, 1'b0);
    check("rst.o_pc", o_pc, '0);
    check("rst.o_inst", o_inst, '0);
    check("rst.o_fault", o_fault, 1'b0);
    check("rst.o_ready", o_ready, 1'b1);
    live.delete();
    done_q.delete();
    mem_q.delete();
    dead = 0;
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    last_due = cyc;
    #1;
    check("rst.after_valid", o_valid, 1'b0);
  endtask

  initial begin
    int k, idx, cnt, first_iss, last_iss;
    lat = 1;
    #1 i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_mem_req_ready = 1'b1;
    #1;
    check("init.o_valid", o_valid, 1'b0);
    check("init.o_pc", o_pc, '0);
    check("init.o_inst", o_inst, '0);
    check("init.o_fault", o_fault, 1'b0);
    check("init.o_mem_req_valid", o_mem_req_valid, 1'b1);
    check("init.o_ready", o_ready, 1'b1);
    i_valid = 1'b0;
    i_mem_req_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // single fetch, L=1
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    expect_head("single", 32'h8000_0000, 32'h13, 1'b0, k);
    check("single.lat", k, 1);
    idle(2);

    // streaming, L=2
    lat = 2;
    pops = 0;
    idx = 0;
    first_iss = 0;
    last_iss = 0;
    for (int n = 0; n < 40 && pops < 16; n++) begin
      cycle(idx < 16, AW'(idx * 4), 1'b1, 1'b1, 1'b0);
      if (fired) begin
        if (idx == 0) first_iss = cyc;
        last_iss = cyc;
        idx++;
      end
    end
    check("stream.issues", idx, 16);
    check("stream.issue_span", last_iss - first_iss, 15);
    check("stream.pops", pops, 16);
    check("stream.pop_span", last_pop - first_pop, 15);

    // back-pressure, L=1
    lat = 1;
    cnt = 0;
    repeat (8) begin
      cycle(1'b1, AW'(32'h200 + cnt * 4), 1'b1, 1'b0, 1'b0);
      if (fired) cnt++;
    end
    check("bp.issues", cnt, 4);
    #1 check("bp.o_ready", o_ready, 1'b0);
    repeat (12) begin
      cycle(cnt < 6, AW'(32'h200 + cnt * 4), 1'b1, 1'b1, 1'b0);
      if (fired) cnt++;
    end
    check("bp.resume", cnt, 6);
    idle(4);

    // flush with one buffered and three in flight
    lat = 1;
    cycle(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    lat = 4;
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h308, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h30C, 1'b1, 1'b0, 1'b0);
    check("flush.in_flight", live.size(), 3);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    check("flush.reissue", fired, 1'b1);
    expect_head("flush", 32'h100, inst_of(32'h100), 1'b0, k);
    idle(3);

    // flush coincident with a response
    lat = 2;
    cycle(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    expect_head("coinc", 32'h500, inst_of(32'h500), 1'b0, k);
    idle(3);

    // fault path
    lat = 1;
    cycle(1'b1, 32'hF000_0010, 1'b1, 1'b0, 1'b0);
    expect_head("fault", 32'hF000_0010, inst_of(32'hF000_0010), 1'b1, k);
    idle(2);

    // asynchronous reset mid-stream
    cycle(1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h604, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h608, 1'b1, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    expect_head("post_rst", 32'h700, inst_of(32'h700), 1'b0, k);
    idle(2);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      lat = $urandom_range(1, 3);
      cycle($urandom_range(0, 3) != 0, AW'($urandom) & ~AW'(3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    for (int n = 0; n < 40 && (live.size() + done_q.size() + dead + mem_q.size()) != 0; n++) idle(1);
    check("drain.empty", live.size() + done_q.size() + dead + mem_q.size(), 0);
    #1 check("drain.o_valid", o_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
